proc_trace_capture: RTL and testbench

Retirement trace capture for the TinyRV1 five-stage pipeline, sitting directly downstream of `Proc`'s trace ports. It aligns the F-stage address/instruction trace with the W-stage writeback data by replaying the pipeline's F→D→X→M→W progression, including stall bubbles. Each retired instruction is pushed into a FIFO as an {addr, inst, data} record, and the FIFO is drained through a val/rdy handshake by a host-side logger or checker.

---
 rtl/proc_trace_capture.sv | 127 ++++++++++++
 tb/tb_proc_trace_capture.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_trace_capture.sv
// proc_trace_capture: replays the F->W progression of the five-stage pipeline
// and buffers each retired {addr, inst, data} record in a val/rdy FIFO.
module proc_trace_capture #(
    parameter int DEPTH = 8,
    parameter int DROPW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_inst,
    input  logic                     trace_stall,
    input  logic [31:0]              trace_data,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROPW-1:0]         drop_count,
    output logic [31:0]              retired
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        val;
        logic [31:0] addr;
        logic [31:0] inst;
    } stage_t;

    stage_t f_s;
    stage_t d_q, x_q, m_q, w_q;
    stage_t d_d, x_d;

    logic [95:0]      mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [DROPW-1:0] drop_q, drop_d;
    logic [31:0]      retired_q, retired_d;

    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic [95:0] head;

    // A stall freezes D and injects a bubble into X; F is refetched later.
    always_comb begin
        f_s = '{val: en, addr: trace_addr, inst: trace_inst};
        d_d = trace_stall ? d_q : f_s;
        x_d = trace_stall ? '0 : d_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= '0;
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            d_q <= d_d;
            x_q <= x_d;
            m_q <= x_q;
            w_q <= m_q;
        end
    end

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        out_val    = (count_q != '0);
        pop        = out_val & out_rdy;
        push       = w_q.val & (~full | pop);
        drop       = w_q.val & full & ~pop;
        wptr_d     = wptr_q + AW'(push);
        rptr_d     = rptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | drop;
        drop_d     = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
        retired_d  = retired_q + 32'(push);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            retired_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            retired_q  <= retired_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {w_q.addr, w_q.inst, trace_data};
        end
    end

    always_comb begin
        head     = mem_q[rptr_q];
        out_addr = out_val ? head[95:64] : '0;
        out_inst = out_val ? head[63:32] : '0;
        out_data = out_val ? head[31:0]  : '0;
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_proc_trace_capture.sv
// tb_proc_trace_capture: scoreboard bench for proc_trace_capture.
// Expected records are queued at fetch time and compared on each pop.
module tb_proc_trace_capture;

    localparam int DEPTH = 8;

    typedef logic [95:0] rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        trace_stall = 1'b0;
    logic        out_rdy = 1'b0;
    logic [31:0] trace_addr = '0;
    logic [31:0] trace_inst = '0;
    logic [31:0] trace_data = '0;
    logic        out_val;
    logic [31:0] out_addr;
    logic [31:0] out_inst;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] retired;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rec_t sb[$];

    always #5 clk = ~clk;

    proc_trace_capture #(.DEPTH(DEPTH), .DROPW(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .trace_addr(trace_addr), .trace_inst(trace_inst),
        .trace_stall(trace_stall), .trace_data(trace_data),
        .out_val(out_val), .out_rdy(out_rdy),
        .out_addr(out_addr), .out_inst(out_inst), .out_data(out_data),
        .count(count), .overflow(overflow),
        .drop_count(drop_count), .retired(retired)
    );

    function automatic logic [31:0] dfun(int c);
        return 32'hD000_0000 + 32'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        trace_data = dfun(cyc);
    endtask

    task automatic drive(input logic e, input logic [31:0] a,
                         input logic [31:0] in, input logic s,
                         input logic r);
        en = e;
        trace_addr = a;
        trace_inst = in;
        trace_stall = s;
        out_rdy = r;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst = 0;
        @(negedge clk);
        rst = 1;
        sb.delete();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        rst = 0;
        #3;
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL reset_val got %b want 0", out_val);
        end
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if ({overflow, drop_count} !== 17'd0) begin
            errors++; $display("FAIL reset_ovf got %b/%0d want 0/0", overflow, drop_count);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL reset_retired got %0d want 0", retired);
        end
        checks++;
        if ({out_addr, out_inst, out_data} !== 96'd0) begin
            errors++; $display("FAIL reset_out got %h want 0", {out_addr, out_inst, out_data});
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_basic();
        logic [31:0] ins [3];
        rec_t        e;
        int          k;
        ins = '{32'h00100093, 32'h00200113, 32'h002081B3};
        k = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 4 && i <= 6) trace_data = 32'(i - 3);
            if (i < 3) begin
                drive(1, 32'h200 + 32'(4 * i), ins[i], 0, 1);
                sb.push_back({32'h200 + 32'(4 * i), ins[i], 32'(i + 1)});
            end else begin
                drive(0, 0, 0, 0, 1);
            end
            if (out_val && out_rdy) begin
                e = sb.pop_front();
                checks++;
                if (i != 5 + k) begin
                    errors++; $display("FAIL basic_cycle got %0d want %0d", i, 5 + k);
                end
                checks++;
                if ({out_addr, out_inst, out_data} !== e) begin
                    errors++; $display("FAIL basic_rec got %h want %h", {out_addr, out_inst, out_data}, e);
                end
                k++;
            end
        end
        checks++;
        if (k != 3 || retired !== 32'd3) begin
            errors++; $display("FAIL basic_retired got %0d/%0d want 3/3", k, retired);
        end
    endtask

    task automatic test_stall();
        rec_t e;
        int   k;
        k = 0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) begin
                drive(1, 32'h200, 32'h00012083, 0, 1);
                sb.push_back({32'h200, 32'h00012083, dfun(cyc + 4)});
            end else if (i == 1) begin
                drive(1, 32'h204, 32'h001081B3, 0, 1);
                sb.push_back({32'h204, 32'h001081B3, dfun(cyc + 5)});
            end else if (i == 2) begin
                drive(1, 32'hBAD0, 32'h00000013, 1, 1);
            end else begin
                drive(0, 0, 0, 0, 1);
            end
            if (out_val && out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stall_extra got %h want none", out_addr);
                end else begin
                    e = sb.pop_front();
                    if ({out_addr, out_inst, out_data} !== e || i != (k == 0 ? 5 : 7)) begin
                        errors++; $display("FAIL stall_rec got %h@%0d want %h", {out_addr, out_inst, out_data}, i, e);
                    end
                end
                k++;
            end
        end
        checks++;
        if (k != 2) begin
            errors++; $display("FAIL stall_count got %0d want 2", k);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i < 10) begin
                drive(1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 0, 0);
                if (i < DEPTH) sb.push_back({32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), dfun(cyc + 4)});
            end else begin
                drive(0, 0, 0, 0, 0);
            end
        end
        checks++;
        if (count !== 4'd8) begin
            errors++; $display("FAIL full_count got %0d want 8", count);
        end
        checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd2) begin
            errors++; $display("FAIL full_drop got %b/%0d want 1/2", overflow, drop_count);
        end
        checks++;
        if (retired !== 32'd8) begin
            errors++; $display("FAIL full_retired got %0d want 8", retired);
        end
        checks++;
        if (out_addr !== 32'h1000) begin
            errors++; $display("FAIL full_head got %h want 00001000", out_addr);
        end
    endtask

    task automatic test_push_pop_full();
        rec_t e;
        int   n;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                drive(1, 32'h2000, 32'hB000, 0, 0);
                sb.push_back({32'h2000, 32'hB000, dfun(cyc + 4)});
            end else begin
                drive(0, 0, 0, 0, i == 4);
            end
            if (out_val && out_rdy) begin
                e = sb.pop_front();
                checks++;
                if ({out_addr, out_inst, out_data} !== e) begin
                    errors++; $display("FAIL pp_rec got %h want %h", {out_addr, out_inst, out_data}, e);
                end
                n++;
            end
        end
        checks++;
        if (n != 1 || count !== 4'd8 || drop_count !== 16'd2) begin
            errors++; $display("FAIL pp_state got pops=%0d cnt=%0d drop=%0d want 1/8/2", n, count, drop_count);
        end
        checks++;
        if (out_addr !== 32'h1004 || retired !== 32'd9) begin
            errors++; $display("FAIL pp_head got %h/%0d want 00001004/9", out_addr, retired);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            drive(0, 0, 0, 0, 1);
            if (out_val && out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL drain_extra got %h want none", out_addr);
                end else begin
                    e = sb.pop_front();
                    if ({out_addr, out_inst, out_data} !== e) begin
                        errors++; $display("FAIL drain_rec got %h want %h", {out_addr, out_inst, out_data}, e);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0 || count !== 4'd0) begin
            errors++; $display("FAIL drain_left got %0d/%0d want 0/0", sb.size(), count);
        end
    endtask

    task automatic test_wrap();
        rec_t e;
        logic ev;
        int   n;
        n = 0;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            tick();
            ev = (i < 40) && (i % 2 == 0);
            drive(ev, 32'h5000 + 32'(4 * i), 32'hC000 + 32'(i), 0, 1'(i % 2));
            if (ev) sb.push_back({32'h5000 + 32'(4 * i), 32'hC000 + 32'(i), dfun(cyc + 4)});
            if (out_val && out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL wrap_extra got %h want none", out_addr);
                end else begin
                    e = sb.pop_front();
                    if ({out_addr, out_inst, out_data} !== e) begin
                        errors++; $display("FAIL wrap_rec got %h want %h", {out_addr, out_inst, out_data}, e);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 20 || count !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL wrap_end got n=%0d cnt=%0d ovf=%b want 20/0/0", n, count, overflow);
        end
    endtask

    task automatic test_async_reset();
        rec_t e;
        int   n;
        n = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 6) drive(1, 32'h3000 + 32'(4 * i), 32'hE000 + 32'(i), 0, 0);
            else drive(0, 0, 0, 0, 0);
        end
        checks++;
        if (count !== 4'd3) begin
            errors++; $display("FAIL ar_pre got %0d want 3", count);
        end
        #2;
        rst = 0;
        #1;
        checks++;
        if (out_val !== 1'b0 || count !== 4'd0 || retired !== 32'd0) begin
            errors++; $display("FAIL ar_now got %b/%0d/%0d want 0/0/0", out_val, count, retired);
        end
        @(negedge clk);
        rst = 1;
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 2) begin
                drive(1, 32'h4000 + 32'(4 * i), 32'hF000 + 32'(i), 0, 1);
                sb.push_back({32'h4000 + 32'(4 * i), 32'hF000 + 32'(i), dfun(cyc + 4)});
            end else begin
                drive(0, 0, 0, 0, 1);
            end
            if (out_val && out_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL ar_extra got %h want none", out_addr);
                end else begin
                    e = sb.pop_front();
                    if ({out_addr, out_inst, out_data} !== e) begin
                        errors++; $display("FAIL ar_rec got %h want %h", {out_addr, out_inst, out_data}, e);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL ar_count got %0d want 2", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_push_pop_full();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
